// File: rtl/uart_compare_loader.sv
// uart_compare_loader
// Receives 8N1 UART bytes, assembles three of them (MSB byte first) into a
// 24-bit compare value and hands it to the seconds counter with a one-cycle
// load strobe. Bad stop bits and all-zero words raise a one-cycle frame_error
// instead. A partial word left idle too long is silently abandoned.
module uart_compare_loader #(
  parameter int          CLKS_PER_BIT  = 1667,
  parameter int          TIMEOUT_BITS  = 20,
  parameter logic [23:0] RESET_COMPARE = 24'd16_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic [23:0] compare_out,
  output logic        update_compare,
  output logic        frame_error,
  output logic        busy
);

  localparam int TW             = $clog2(CLKS_PER_BIT);
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IW             = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0] MID_BIT    = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0] LAST_TICK  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  state_t        state_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic [TW-1:0] timer_q;
  logic [IW-1:0] idle_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [1:0]    byte_idx_q;
  logic [15:0]   hold_q;
  logic [23:0]   compare_q;
  logic          update_q;
  logic          frame_error_q;
  logic [23:0]   word_d;

  // Candidate word when the third byte's stop bit is accepted.
  assign word_d = {hold_q, shift_q};

  assign compare_out    = compare_q;
  assign update_compare = update_q;
  assign frame_error    = frame_error_q;
  assign busy           = (state_q != ST_IDLE);

  // Two-flop synchronizer; idles high so reset does not fake a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver FSM, word assembly, idle timeout and registered strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      idle_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      byte_idx_q    <= '0;
      hold_q        <= '0;
      compare_q     <= RESET_COMPARE;
      update_q      <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      update_q      <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            timer_q    <= '0;
            idle_cnt_q <= '0;
            state_q    <= ST_START;
          end else if (byte_idx_q != 2'd0) begin
            // Abandon a partial word once the line has been quiet too long.
            if (idle_cnt_q == IDLE_LIMIT) begin
              byte_idx_q <= 2'd0;
              idle_cnt_q <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end else begin
            idle_cnt_q <= '0;
          end
        end

        ST_START: begin
          if (timer_q == MID_BIT) begin
            timer_q <= '0;
            if (!rx_s_q) begin
              bit_cnt_q <= '0;
              state_q   <= ST_DATA;
            end else begin
              // Start bit did not survive to mid-bit: a glitch, not an error.
              state_q <= ST_IDLE;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (timer_q == LAST_TICK) begin
            timer_q <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (timer_q == LAST_TICK) begin
            timer_q <= '0;
            if (rx_s_q) begin
              state_q <= ST_IDLE;
              case (byte_idx_q)
                2'd0: begin
                  hold_q[15:8] <= shift_q;
                  byte_idx_q   <= 2'd1;
                end
                2'd1: begin
                  hold_q[7:0] <= shift_q;
                  byte_idx_q  <= 2'd2;
                end
                default: begin
                  // Zero would underflow the counter's compare-1 logic.
                  if (word_d != 24'd0) begin
                    compare_q <= word_d;
                    update_q  <= 1'b1;
                  end else begin
                    frame_error_q <= 1'b1;
                  end
                  byte_idx_q <= 2'd0;
                end
              endcase
            end else begin
              frame_error_q <= 1'b1;
              byte_idx_q    <= 2'd0;
              state_q       <= ST_WAIT_HIGH;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_WAIT_HIGH: begin
          // A held-low break must not be mistaken for a new start bit.
          if (rx_s_q) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_compare_loader.sv
// Directed testbench for uart_compare_loader at 16 clocks per bit.
module tb_uart_compare_loader;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic [23:0] compare_out;
  logic        update_compare;
  logic        frame_error;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int          upd_cnt = 0;
  int          ferr_cnt = 0;
  int          overlap_cnt = 0;
  int          dbl_upd_cnt = 0;
  logic [23:0] upd_val = 24'd0;
  logic        prev_upd = 1'b0;

  always #5 clk = ~clk;

  uart_compare_loader #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_BITS (TOB),
    .RESET_COMPARE(24'd16_000_000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx            (rx),
    .compare_out   (compare_out),
    .update_compare(update_compare),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  // Pulse bookkeeping, sampled on the falling edge.
  always @(negedge clk) begin
    if (update_compare) begin
      upd_cnt = upd_cnt + 1;
      upd_val = compare_out;
      if (prev_upd) dbl_upd_cnt = dbl_upd_cnt + 1;
    end
    if (frame_error) begin
      ferr_cnt = ferr_cnt + 1;
      if (update_compare) overlap_cnt = overlap_cnt + 1;
    end
    prev_upd = update_compare;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop_bit;
    wait_cycles(CPB);
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b1);
    send_frame(b1, 1'b1);
    send_frame(b2, 1'b1);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx = 1'b1;
    wait_cycles(3);
    checks++; if (compare_out !== 24'd16_000_000) begin errors++; $display("FAIL reset_compare: got %0d want %0d", compare_out, 24'd16_000_000); end
    checks++; if (update_compare !== 1'b0) begin errors++; $display("FAIL reset_update: got %b want 0", update_compare); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    wait_cycles(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    $display("test_reset: compare_out=%0d busy=%b", compare_out, busy);
  endtask

  task automatic test_valid_word;
    int u0, f0;
    u0 = upd_cnt; f0 = ferr_cnt;
    // First byte 0x00 sent by hand so busy can be probed mid-frame.
    rx = 1'b0;
    wait_cycles(4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL valid_busy_mid: got %b want 1", busy); end
    wait_cycles(CPB * 9 - 4);
    rx = 1'b1;
    wait_cycles(CPB);
    send_frame(8'h00, 1'b1);
    send_frame(8'h10, 1'b1);
    wait_cycles(4);
    checks++; if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL valid_upd_count: got %0d want 1", upd_cnt - u0); end
    checks++; if (upd_val !== 24'h000010) begin errors++; $display("FAIL valid_value_at_strobe: got %h want 000010", upd_val); end
    checks++; if (compare_out !== 24'h000010) begin errors++; $display("FAIL valid_compare: got %h want 000010", compare_out); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL valid_ferr: got %0d want 0", ferr_cnt - f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL valid_busy_after: got %b want 0", busy); end
    $display("test_valid_word: compare_out=%h updates=%0d", compare_out, upd_cnt - u0);
  endtask

  task automatic test_reset_mid_frame;
    int u0;
    rx = 1'b0;
    wait_cycles(40);
    reset_n = 1'b0;
    wait_cycles(2);
    checks++; if (compare_out !== 24'd16_000_000) begin errors++; $display("FAIL midreset_compare: got %0d want %0d", compare_out, 24'd16_000_000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (update_compare !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL midreset_strobes: got upd=%b ferr=%b want 0 0", update_compare, frame_error); end
    rx = 1'b1;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(20);
    u0 = upd_cnt;
    send_word(8'h0A, 8'hBC, 8'hDE);
    wait_cycles(4);
    checks++; if (compare_out !== 24'h0ABCDE) begin errors++; $display("FAIL midreset_word: got %h want 0abcde", compare_out); end
    checks++; if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL midreset_upd_count: got %0d want 1", upd_cnt - u0); end
    $display("test_reset_mid_frame: compare_out=%h", compare_out);
  endtask

  task automatic test_frame_error;
    int u0, f0;
    u0 = upd_cnt; f0 = ferr_cnt;
    send_frame(8'h5A, 1'b0);
    wait_cycles(100);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
    checks++; if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL ferr_upd_during_low: got %0d want 0", upd_cnt - u0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_in_break: got %b want 1", busy); end
    rx = 1'b1;
    wait_cycles(CPB);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_after_break: got %b want 0", busy); end
    send_word(8'h01, 8'h02, 8'h03);
    wait_cycles(4);
    checks++; if (compare_out !== 24'h010203) begin errors++; $display("FAIL ferr_recovery_word: got %h want 010203", compare_out); end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_total: got %0d want 1", ferr_cnt - f0); end
    $display("test_frame_error: compare_out=%h frame_errors=%0d", compare_out, ferr_cnt - f0);
  endtask

  task automatic test_timeout;
    send_frame(8'hAA, 1'b1);
    wait_cycles(330);
    send_word(8'h00, 8'h00, 8'h05);
    wait_cycles(4);
    checks++; if (compare_out !== 24'h000005) begin errors++; $display("FAIL timeout_expired: got %h want 000005", compare_out); end
    $display("test_timeout (330 gap): compare_out=%h", compare_out);
    send_frame(8'hAA, 1'b1);
    wait_cycles(300);
    send_word(8'h00, 8'h00, 8'h05);
    wait_cycles(4);
    checks++; if (compare_out !== 24'hAA0000) begin errors++; $display("FAIL timeout_not_expired: got %h want aa0000", compare_out); end
    $display("test_timeout (300 gap): compare_out=%h", compare_out);
    // Let the stray 0x05 partial word time out.
    wait_cycles(400);
  endtask

  task automatic test_zero_word;
    int u0, f0;
    u0 = upd_cnt; f0 = ferr_cnt;
    send_word(8'h00, 8'h00, 8'h00);
    wait_cycles(4);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL zero_ferr: got %0d want 1", ferr_cnt - f0); end
    checks++; if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL zero_upd: got %0d want 0", upd_cnt - u0); end
    checks++; if (compare_out !== 24'hAA0000) begin errors++; $display("FAIL zero_compare_kept: got %h want aa0000", compare_out); end
    $display("test_zero_word: compare_out=%h frame_errors=%0d", compare_out, ferr_cnt - f0);
  endtask

  task automatic test_start_glitch;
    int u0, f0;
    u0 = upd_cnt; f0 = ferr_cnt;
    send_frame(8'h12, 1'b1);
    wait_cycles(50);
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(12);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
    wait_cycles(30);
    send_frame(8'h34, 1'b1);
    send_frame(8'h56, 1'b1);
    wait_cycles(4);
    checks++; if (compare_out !== 24'h123456) begin errors++; $display("FAIL glitch_index_kept: got %h want 123456", compare_out); end
    checks++; if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL glitch_upd_count: got %0d want 1", upd_cnt - u0); end
    $display("test_start_glitch: compare_out=%h", compare_out);
  endtask

  task automatic test_back_to_back;
    int u0;
    logic [23:0] first_val;
    u0 = upd_cnt;
    send_word(8'h11, 8'h22, 8'h33);
    first_val = upd_val;
    send_word(8'h44, 8'h55, 8'h66);
    wait_cycles(4);
    checks++; if (first_val !== 24'h112233) begin errors++; $display("FAIL b2b_first: got %h want 112233", first_val); end
    checks++; if (compare_out !== 24'h445566) begin errors++; $display("FAIL b2b_second: got %h want 445566", compare_out); end
    checks++; if (upd_cnt - u0 !== 2) begin errors++; $display("FAIL b2b_upd_count: got %0d want 2", upd_cnt - u0); end
    checks++; if (dbl_upd_cnt !== 0) begin errors++; $display("FAIL update_consecutive: got %0d want 0", dbl_upd_cnt); end
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL ferr_with_update: got %0d want 0", overlap_cnt); end
    $display("test_back_to_back: first=%h second=%h", first_val, compare_out);
  endtask

  initial begin
    test_reset();
    test_valid_word();
    test_reset_mid_frame();
    test_frame_error();
    test_timeout();
    test_zero_word();
    test_start_glitch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_compare_loader.md
# uart_compare_loader

Serial front end for the seconds counter. It receives 8N1 UART bytes on one pin and assembles three consecutive bytes (MSB first) into a 24-bit compare value. It drives that value and a one-cycle load strobe directly into the seven-segment seconds counter's `compare_in` / `update_compare` inputs. Malformed frames and stale partial words are discarded, so the counter only ever sees complete, nonzero values.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1667: clock cycles per UART bit (16 MHz / 9600 baud). Legal range ≥ 4.
- `TIMEOUT_BITS`, default 20: idle bit-times after which a partially received word is abandoned.
- `RESET_COMPARE`, default 24'd16_000_000: value of `compare_out` after reset.

Ports:
- `clk`, input, 1: single clock; all logic is in this domain.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `rx`, input, 1: asynchronous UART line; idles high.
- `compare_out`, output, 24: last accepted compare value. Connects to the counter's `compare_in`.
- `update_compare`, output, 1: one-cycle strobe when `compare_out` takes a new value.
- `frame_error`, output, 1: one-cycle pulse on a bad stop bit or a zero word.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. All decisions use `rx_s`.
- The FSM has five states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when `rx_s` is 0, clear the bit-timer and go to START.
  - START: when the bit-timer reaches (CLKS_PER_BIT-1)/2 (mid-bit), sample `rx_s`.
    - If 0: clear the bit-timer and go to DATA.
    - If 1: treat it as a glitch and return to IDLE. No error is flagged.
  - DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first, into the shift register. After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
    - If 1: the byte is accepted. Go to IDLE.
    - If 0: pulse `frame_error`, discard the byte, clear the byte index, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` is 1, then go to IDLE. A held-low break therefore never retriggers reception.
- Word assembly uses a 2-bit byte index (0..2).
  - Byte 0 goes to bits [23:16], byte 1 to [15:8], byte 2 to [7:0] of a holding register.
  - On acceptance of byte 2:
    - If the assembled word is nonzero, load `compare_out` and pulse `update_compare`.
    - If the word is zero, pulse `frame_error` and leave `compare_out` unchanged. A value of 0 would underflow the downstream compare−1 logic.
  - In either case the index returns to 0.
- Timeout: in IDLE with the byte index nonzero, an idle counter runs. When it reaches TIMEOUT_BITS × CLKS_PER_BIT cycles, the byte index clears. No error pulse is generated. The idle counter clears on leaving IDLE.
- Widths:
  - The bit-timer is $clog2(CLKS_PER_BIT) bits wide.
  - The idle counter is wide enough for TIMEOUT_BITS × CLKS_PER_BIT.
  - No counter may wrap inside its legal range.

## Timing
- Reset (asynchronous, while `reset_n` = 0):
  - FSM = IDLE, byte index = 0, all counters = 0.
  - Synchronizer flops = 1.
  - `compare_out` = RESET_COMPARE.
  - `update_compare` = 0, `frame_error` = 0, `busy` = 0.
- Reset deassertion mid-frame: the partial byte and word are lost. Reception restarts at the next falling edge of `rx_s`.
- Input latency: 2 cycles from `rx` to `rx_s`.
- Strobe timing: `update_compare` and the new `compare_out` appear on the clock edge after the third stop-bit sample.
  - `compare_out` holds that value until the next accepted word.
  - `update_compare` is never high for two consecutive cycles.
- `frame_error` is registered and lasts one cycle. It is never asserted in the same cycle as `update_compare`.
- Back-to-back frames are supported: a start bit detected in the first IDLE cycle after STOP is received correctly. The minimum stop time is one bit.

## Test plan
Use CLKS_PER_BIT = 16 and TIMEOUT_BITS = 20 in simulation.
- **Reset defaults:** assert `reset_n` = 0 mid-frame, then release. Require `compare_out` = 16_000_000, all strobes 0, `busy` = 0, and correct reception of the next full word.
- **Valid word:** send bytes 0x00, 0x00, 0x10. Require exactly one `update_compare` pulse, with `compare_out` = 24'h000010 in the same cycle. The counter downstream then advances its digit every 16 cycles.
- **Frame error recovery:** send a byte with stop bit 0, hold `rx` low for 100 cycles, then send 0x01, 0x02, 0x03. Require one `frame_error` pulse, no update during the low period, then `compare_out` = 24'h010203.
- **Timeout:**
  - Send 0xAA, idle 330 cycles, then send 0x00, 0x00, 0x05: require `compare_out` = 24'h000005.
  - Repeat with a 300-cycle gap: require `compare_out` = 24'hAA0000, because the timeout has not expired and the third byte is dropped into the next word.
- **Zero word:** send 0x00, 0x00, 0x00. Require one `frame_error` pulse, no `update_compare`, and `compare_out` unchanged.
- **Start glitch:** drive a 3-cycle low pulse on `rx`. Require return to IDLE, no error, and the byte index unchanged.
